// File: rtl/load_id_tracker_pkg.sv
// Shared load-buffer types: per-slot metadata and the load size encoding.
package load_id_tracker_pkg;

    localparam int unsigned LD_NR_ENTRIES   = 8;
    localparam int unsigned DCACHE_ID_WIDTH = 3;
    localparam int unsigned TRANS_ID_WIDTH  = 3;
    localparam int unsigned LD_XLEN         = 64;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_D = 2'b11
    } ld_size_e;

    typedef struct packed {
        logic [TRANS_ID_WIDTH-1:0] trans_id;
        logic [2:0]                offset;
        ld_size_e                  size;
        logic                      is_signed;
        logic                      killed;
    } ldbuf_entry_t;

endpackage

// File: rtl/load_id_tracker_if.sv
// Load-unit / dcache side bundle of the load ID tracker.
// Handshake: an allocation happens on a cycle where alloc_valid_i and alloc_ready_o are both high;
// alloc_ready_o never depends on alloc_valid_i. rsp/abort/result are single-cycle pulses without backpressure.
interface load_id_tracker_if;
    import load_id_tracker_pkg::*;

    logic                       alloc_valid_i;
    logic                       alloc_ready_o;
    logic [TRANS_ID_WIDTH-1:0]  alloc_trans_id_i;
    logic [2:0]                 alloc_offset_i;
    logic [1:0]                 alloc_size_i;
    logic                       alloc_signed_i;
    logic [DCACHE_ID_WIDTH-1:0] alloc_id_o;
    logic                       abort_valid_i;
    logic [DCACHE_ID_WIDTH-1:0] abort_id_i;
    logic                       rsp_valid_i;
    logic [DCACHE_ID_WIDTH-1:0] rsp_id_i;
    logic [LD_XLEN-1:0]         rsp_data_i;
    logic                       result_valid_o;
    logic [TRANS_ID_WIDTH-1:0]  result_trans_id_o;
    logic [LD_XLEN-1:0]         result_data_o;

    modport slave (
        input  alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_signed_i,
        input  abort_valid_i, abort_id_i, rsp_valid_i, rsp_id_i, rsp_data_i,
        output alloc_ready_o, alloc_id_o, result_valid_o, result_trans_id_o, result_data_o
    );

    modport master (
        output alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_signed_i,
        output abort_valid_i, abort_id_i, rsp_valid_i, rsp_id_i, rsp_data_i,
        input  alloc_ready_o, alloc_id_o, result_valid_o, result_trans_id_o, result_data_o
    );

endinterface

// File: rtl/load_id_tracker_data_align.sv
// Combinational load data alignment: shift the addressed bytes down, then sign/zero-extend.
module load_data_align
    import load_id_tracker_pkg::*;
#(
    parameter int unsigned XLEN = LD_XLEN
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      offset_i,
    input  ld_size_e        size_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = data_i >> {offset_i, 3'b000};

    always_comb begin
        case (size_i)
            LD_B:    data_o = {{(XLEN-8){signed_i & shifted[7]}}, shifted[7:0]};
            LD_H:    data_o = {{(XLEN-16){signed_i & shifted[15]}}, shifted[15:0]};
            LD_W:    data_o = {{(XLEN-32){signed_i & shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_id_tracker.sv
// Hands out dcache IDs to issued loads and turns dcache responses into aligned
// writeback results tagged with the original scoreboard trans_id.
module load_id_tracker
    import load_id_tracker_pkg::*;
#(
    parameter int unsigned NrEntries    = LD_NR_ENTRIES,
    parameter int unsigned IdWidth      = DCACHE_ID_WIDTH,
    parameter int unsigned TransIdWidth = TRANS_ID_WIDTH,
    parameter int unsigned XLEN         = LD_XLEN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    output logic              empty_o,
    load_id_tracker_if.slave  ld
);

    logic [NrEntries-1:0]     valid_q, valid_d;
    ldbuf_entry_t [NrEntries-1:0] entry_q, entry_d;
    logic [IdWidth-1:0]       free_id;
    logic                     alloc_fire;
    logic                     rsp_abort_same;
    logic                     rsp_live;
    logic [XLEN-1:0]          aligned;
    logic                     result_valid_q;
    logic [TransIdWidth-1:0]  result_trans_id_q;
    logic [XLEN-1:0]          result_data_q;

    // Lowest-index free slot, searched from the top so index 0 wins.
    always_comb begin
        free_id = '0;
        for (int i = NrEntries - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_id = IdWidth'(i);
        end
    end

    assign ld.alloc_ready_o = ~&valid_q;
    assign ld.alloc_id_o    = free_id;
    assign empty_o          = ~|valid_q;
    assign alloc_fire       = ld.alloc_valid_i & ld.alloc_ready_o;

    assign rsp_abort_same = ld.abort_valid_i & (ld.abort_id_i == ld.rsp_id_i);
    // A flush in the response cycle kills the load just like an earlier flush would.
    assign rsp_live = ld.rsp_valid_i & valid_q[ld.rsp_id_i] & ~entry_q[ld.rsp_id_i].killed
                    & ~flush_i & ~rsp_abort_same;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        for (int i = 0; i < NrEntries; i++) begin
            if (flush_i && valid_q[i]) entry_d[i].killed = 1'b1;
            if ((ld.rsp_valid_i && ld.rsp_id_i == IdWidth'(i)) ||
                (ld.abort_valid_i && ld.abort_id_i == IdWidth'(i))) begin
                valid_d[i]        = 1'b0;
                entry_d[i].killed = 1'b0;
            end
            // Only a free slot is allocated, so this never collides with a legal free.
            if (alloc_fire && free_id == IdWidth'(i)) begin
                valid_d[i]           = 1'b1;
                entry_d[i].trans_id  = ld.alloc_trans_id_i;
                entry_d[i].offset    = ld.alloc_offset_i;
                entry_d[i].size      = ld_size_e'(ld.alloc_size_i);
                entry_d[i].is_signed = ld.alloc_signed_i;
                entry_d[i].killed    = 1'b0;
            end
        end
    end

    load_data_align #(
        .XLEN (XLEN)
    ) u_align (
        .data_i   (ld.rsp_data_i),
        .offset_i (entry_q[ld.rsp_id_i].offset),
        .size_i   (entry_q[ld.rsp_id_i].size),
        .signed_i (entry_q[ld.rsp_id_i].is_signed),
        .data_o   (aligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q           <= '0;
            entry_q           <= '0;
            result_valid_q    <= 1'b0;
            result_trans_id_q <= '0;
            result_data_q     <= '0;
        end else begin
            valid_q        <= valid_d;
            entry_q        <= entry_d;
            result_valid_q <= rsp_live;
            if (rsp_live) begin
                result_trans_id_q <= entry_q[ld.rsp_id_i].trans_id;
                result_data_q     <= aligned;
            end
        end
    end

    assign ld.result_valid_o    = result_valid_q;
    assign ld.result_trans_id_o = result_trans_id_q;
    assign ld.result_data_o     = result_data_q;

    rsp_to_live_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ld.rsp_valid_i |-> valid_q[ld.rsp_id_i]);

endmodule

// File: tb/tb_load_id_tracker.sv
// Self-checking bench for load_id_tracker: directed cases plus a random mix, with a result scoreboard.
module tb_load_id_tracker;
    import load_id_tracker_pkg::*;

    localparam int W = TRANS_ID_WIDTH + LD_XLEN;

    logic clk;
    logic rst_n;
    logic flush;
    logic empty;

    load_id_tracker_if u_if ();

    load_id_tracker dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .empty_o (empty),
        .ld      (u_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_valid  [8];
    bit         m_killed [8];
    logic [2:0] m_tid    [8];
    logic [2:0] m_off    [8];
    logic [1:0] m_size   [8];
    bit         m_sgn    [8];

    logic [W-1:0] exp_q[$];
    int           due_q[$];

    // Byte-by-byte extraction, independent of the shift-based datapath.
    function automatic logic [63:0] ref_align(input logic [63:0] d, input int off, input int sz, input bit sgn);
        int          nb = 1 << sz;
        logic [63:0] r  = '0;
        for (int k = 0; k < nb; k++) begin
            if (off + k < 8) r[k*8 +: 8] = d[(off+k)*8 +: 8];
        end
        if (sgn && r[nb*8-1]) begin
            for (int b = nb * 8; b < 64; b++) r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit model_empty();
        for (int i = 0; i < 8; i++) if (m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i]  = 1'b0;
            m_killed[i] = 1'b0;
        end
    endfunction

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.result_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", u_if.result_valid_o, 1'b0);
                end else begin
                    logic [W-1:0] e;
                    int           d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("result_trans_id", u_if.result_trans_id_o, e[W-1 -: TRANS_ID_WIDTH]);
                    check("result_data", u_if.result_data_o, e[LD_XLEN-1:0]);
                    check("result_latency", cyc, d);
                end
            end else if (exp_q.size() != 0 && due_q[0] <= cyc) begin
                check("missing_result", u_if.result_valid_o, 1'b1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        u_if.alloc_valid_i    = 1'b0;
        u_if.alloc_trans_id_i = '0;
        u_if.alloc_offset_i   = '0;
        u_if.alloc_size_i     = '0;
        u_if.alloc_signed_i   = 1'b0;
        u_if.abort_valid_i    = 1'b0;
        u_if.abort_id_i       = '0;
        u_if.rsp_valid_i      = 1'b0;
        u_if.rsp_id_i         = '0;
        u_if.rsp_data_i       = '0;
        flush                 = 1'b0;
    endtask

    task automatic step(input bit a_v, input logic [2:0] tid, input logic [2:0] off, input logic [1:0] sz,
                        input bit sgn, input bit fl, input bit ab_v, input logic [2:0] ab_id,
                        input bit r_v, input logic [2:0] r_id, input logic [63:0] r_data);
        int fid;
        fid = model_free();
        check("empty", empty, model_empty());
        check("alloc_ready", u_if.alloc_ready_o, fid >= 0);
        if (a_v && fid >= 0) check("alloc_id", u_if.alloc_id_o, fid);

        u_if.alloc_valid_i    = a_v;
        u_if.alloc_trans_id_i = tid;
        u_if.alloc_offset_i   = off;
        u_if.alloc_size_i     = sz;
        u_if.alloc_signed_i   = sgn;
        u_if.abort_valid_i    = ab_v;
        u_if.abort_id_i       = ab_id;
        u_if.rsp_valid_i      = r_v;
        u_if.rsp_id_i         = r_id;
        u_if.rsp_data_i       = r_data;
        flush                 = fl;

        if (r_v && m_valid[r_id] && !m_killed[r_id] && !fl && !(ab_v && ab_id == r_id)) begin
            exp_q.push_back({m_tid[r_id], ref_align(r_data, m_off[r_id], m_size[r_id], m_sgn[r_id])});
            due_q.push_back(cyc + 1);
        end

        if (fl) for (int i = 0; i < 8; i++) if (m_valid[i]) m_killed[i] = 1'b1;
        if (r_v)  m_valid[r_id]  = 1'b0;
        if (ab_v) m_valid[ab_id] = 1'b0;
        if (a_v && fid >= 0) begin
            m_valid[fid]  = 1'b1;
            m_killed[fid] = 1'b0;
            m_tid[fid]    = tid;
            m_off[fid]    = off;
            m_size[fid]   = sz;
            m_sgn[fid]    = sgn;
        end

        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic alloc(input logic [2:0] tid, input logic [2:0] off, input logic [1:0] sz, input bit sgn);
        step(1'b1, tid, off, sz, sgn, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0);
    endtask

    task automatic alloc_rand();
        alloc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic rsp(input logic [2:0] id, input logic [63:0] data);
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, id, data);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result_valid", u_if.result_valid_o, 1'b0);
        check("reset_result_tid", u_if.result_trans_id_o, 0);
        check("reset_result_data", u_if.result_data_o, 0);
        check("reset_alloc_ready", u_if.alloc_ready_o, 1'b1);
        check("reset_empty", empty, 1'b1);
        check("reset_alloc_id", u_if.alloc_id_o, 0);
        rst_n = 1'b1;
        idle();

        // signed word at offset 4
        alloc(3'd5, 3'd4, LD_W, 1'b1);
        rsp(3'd0, 64'h8000_0001_0000_0000);
        idle();

        // fill all slots, free one, reuse it
        for (int i = 0; i < 8; i++) alloc_rand();
        idle();
        rsp(3'd3, rnd64());
        alloc_rand();
        for (int i = 0; i < 8; i++) rsp(3'(i), rnd64());
        idle();

        // flush kills outstanding loads
        alloc_rand();
        alloc_rand();
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0);
        rsp(3'd1, rnd64());
        rsp(3'd0, rnd64());
        idle();

        // abort frees a slot without a result
        alloc_rand();
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 64'd0);
        idle();

        // rsp and abort to the same slot
        for (int i = 0; i < 3; i++) alloc_rand();
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2, rnd64());
        alloc_rand();
        for (int i = 0; i < 3; i++) rsp(3'(i), rnd64());
        idle();

        // unsigned byte at the top offset
        alloc(3'd1, 3'd7, LD_B, 1'b0);
        rsp(3'd0, 64'hF012_3456_789A_BCDE);
        idle();

        // flush and rsp together, then flush and alloc together
        alloc_rand();
        step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, rnd64());
        alloc_rand();
        step(1'b1, 3'd6, 3'd2, LD_H, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0);
        rsp(3'd1, rnd64());
        rsp(3'd0, rnd64());
        idle();

        // random mix
        for (int n = 0; n < 200; n++) begin
            int sel = $urandom_range(0, 19);
            int pick = -1;
            for (int t = 0; t < 8 && pick < 0; t++) begin
                int c = $urandom_range(0, 7);
                if (m_valid[c]) pick = c;
            end
            if (sel == 0) begin
                step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0);
            end else if (sel == 1 && pick >= 0) begin
                step(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'(pick), 1'b0, 3'd0, 64'd0);
            end else if (sel < 11 && model_free() >= 0) begin
                alloc_rand();
            end else if (pick >= 0) begin
                rsp(3'(pick), rnd64());
            end else begin
                idle();
            end
        end
        for (int i = 0; i < 8; i++) if (m_valid[i]) rsp(3'(i), rnd64());
        idle();

        // asynchronous reset in the middle of a cycle
        alloc_rand();
        alloc_rand();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_empty", empty, 1'b1);
        check("async_reset_ready", u_if.alloc_ready_o, 1'b1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alloc_rand();
        rsp(3'd0, rnd64());

        repeat (3) idle();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_id_tracker.md
Name: load_id_tracker

Overview:
- Tracks outstanding loads between the CVA6 load unit and the HPDcache request port.
- At issue, gives each load a free dcache transaction ID (CVA6ConfigDcacheIdWidth bits). Stores the scoreboard trans_id, byte offset, size and sign for that load.
- When the dcache response returns, aligns and sign/zero-extends the data, then presents it to the load writeback port with the original scoreboard trans_id.
- Sits directly downstream of the load unit issue logic and upstream of the HPDcache load request/response ports.

Parameters:
- NrEntries, 8, number of outstanding load slots (matches NrLoadBufEntries).
- IdWidth, 3, dcache request ID width; must equal $clog2(NrEntries).
- TransIdWidth, 3, scoreboard transaction ID width ($clog2(NrScoreboardEntries)).
- XLEN, 64, data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; mark all live entries killed
- alloc_valid_i  in  1  load unit requests a slot
- alloc_ready_o  out  1  a free slot exists (registered state only)
- alloc_trans_id_i  in  TransIdWidth  scoreboard ID of the load
- alloc_offset_i  in  3  byte offset within the 64-bit word
- alloc_size_i  in  2  00 byte, 01 half, 10 word, 11 dword
- alloc_signed_i  in  1  sign-extend result
- alloc_id_o  out  IdWidth  dcache ID assigned (combinational, valid with alloc handshake)
- abort_valid_i  in  1  the previously allocated request never reached the cache (exception / TLB miss abort)
- abort_id_i  in  IdWidth  slot to free immediately
- rsp_valid_i  in  1  dcache load response
- rsp_id_i  in  IdWidth  response ID
- rsp_data_i  in  XLEN  raw 64-bit word
- result_valid_o  out  1  writeback valid (no backpressure)
- result_trans_id_o  out  TransIdWidth  scoreboard ID
- result_data_o  out  XLEN  aligned, extended data
- empty_o  out  1  no slot in use (used by fence logic)

Behaviour:
- Per-slot state is valid, killed, trans_id, offset, size and signed.
- Reset values: all valid=0, killed=0, result_valid_o=0, result_trans_id_o=0, result_data_o=0. This gives alloc_ready_o=1 and empty_o=1.
- Allocation:
  - Handshake is alloc_valid_i & alloc_ready_o.
  - alloc_id_o is the lowest-index slot with valid=0 in registered state.
  - On handshake the slot is set valid=1, killed=0 and the fields are captured at the clock edge.
- Response:
  - On rsp_valid_i the slot rsp_id_i is cleared at the clock edge.
  - If the slot was live and not killed, result_valid_o=1 next cycle (1-cycle latency) with the stored trans_id.
  - If the slot was killed, the response is dropped silently; the slot is still freed.
- Data path:
  - shifted = rsp_data_i >> (offset*8).
  - Keep low 8/16/32/64 bits according to size.
  - Upper bits are filled with the MSB of the kept field if signed, else zero.
- Abort: abort_valid_i clears the slot immediately with no result. An abort of a free slot is ignored.
- Flush: on flush_i, every valid slot gets killed=1. Slots stay valid until their response arrives, so IDs are never reused while the cache may still answer.
- Simultaneous events:
  - A slot freed by rsp or abort in cycle N is not allocatable until cycle N+1.
  - Flush and alloc in the same cycle: the new entry is not killed. The load unit gates alloc_valid_i during flush.
  - Flush and rsp to the same slot in the same cycle: the response is dropped.
  - rsp and abort to the same slot: abort has priority; no result.
- Full: alloc_ready_o=0 when all NrEntries slots are valid, including killed ones.
- empty_o = no valid slot.
- A response to a non-valid slot is a protocol error. It produces no result, and an assertion flags it.
- Reset mid-operation clears everything asynchronously. Pending responses after reset are the system's responsibility, since the cache is reset together with this block.

Decomposition:
- Shared package (cva6 ld types): the ldbuf_entry_t struct (trans_id, offset, size, signed, killed) and the size encoding constants LD_B/LD_H/LD_W/LD_D.
- IdWidth is derived from the config's DcacheIdWidth.
- One natural sub-module, load_data_align: combinational shift plus extend. It is reused by the store-to-load forwarding path.
- Slot search uses the existing lzc from common_cells.

Test Plan:
- Reset, then alloc trans_id=5, offset=4, size=10, signed=1 → alloc_id_o=0. Then rsp id=0 data=0x8000_0001_0000_0000 → next cycle result_valid_o=1, trans_id=5, data=0xFFFF_FFFF_8000_0001.
- Allocate 8 slots back-to-back → IDs 0..7, alloc_ready_o=0 after the 8th. Rsp id=3 → alloc_ready_o=1 next cycle, and the next alloc gets id 3.
- Allocate ids 0,1, then flush_i, then rsp id=1 and id=0 → no result_valid_o, empty_o=1 after the second response.
- Alloc id 0, then abort_valid_i id 0 → slot free next cycle, no result, empty_o=1.
- Rsp id=2 and abort id=2 in the same cycle with slot 2 live → no result, slot freed. Rsp to free slot 4 → no result, assertion fires.
- Byte unsigned load: offset=7, size=00, data=0xF0xx_xxxx_xxxx_xxxx → result_data_o=0x0000_0000_0000_00F0.
